// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the floor_display seven-segment
//             driver: segment encodings, the digit-to-segment table, the
//             converter FSM state type and a BCD sizing helper.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } disp_state_t;

    // Active-low segments, bit order g..a.
    localparam seg_t SEG_BLANK = 7'b111_1111;
    localparam seg_t SEG_DASH  = 7'b011_1111;

    localparam seg_t SEG_TABLE [10] = '{
        7'b100_0000,  // 0
        7'b111_1001,  // 1
        7'b010_0100,  // 2
        7'b011_0000,  // 3
        7'b001_1001,  // 4
        7'b001_0010,  // 5
        7'b000_0010,  // 6
        7'b111_1000,  // 7
        7'b000_0000,  // 8
        7'b001_0000   // 9
    };

    // Number of BCD nibbles needed for a value_w-bit binary number:
    // ceil(value_w*log10(2) + 1), which for value_w >= 1 is
    // floor(value_w*log10(2)) + 2. Never fewer than the displayed digits.
    function automatic int bcd_digits(input int value_w, input int num_digits);
        int n;
        n = (value_w * 30103) / 100000 + 2;
        if (n < num_digits) begin
            n = num_digits;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational BCD digit to active-low seven-segment decode.
//             Nibbles above 9 decode to a blank digit.
//  Ports    : i_digit - BCD digit in
//             o_seg   - segments out, active-low, bit order g..a
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_TABLE[i_digit];
        end
    end

endmodule
`default_nettype wire

// File: rtl/floor_display.sv
`default_nettype none
// ============================================================================
//  Module   : floor_display
//  Purpose  : Multi-digit seven-segment driver. Accepts a binary value over a
//             valid/ready handshake, converts it to BCD with a sequential
//             double-dabble engine (one bit per cycle), then registers the
//             segment outputs with leading-zero blanking and overflow dashes.
//  Ports    : clk, reset     - clock, synchronous active-high reset
//             value_in       - binary value to display
//             value_valid    - value_in valid this cycle
//             value_ready    - block can accept a new value
//             moving         - blink request (blink build only)
//             hex_out        - NUM_DIGITS x 7 active-low segments, digit 0 low
//             overflow       - last accepted value exceeds NUM_DIGITS digits
//  Options  : FLOOR_DISPLAY_BLINK_EN - enables the moving-blink prescaler
//  Revision : 1.0 - initial release
// ============================================================================
module floor_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int VALUE_W       = 8,
    parameter int BLANK_LEADING = 1,
    parameter int BLINK_DIV     = 25_000_000
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VALUE_W-1:0]      value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    moving,
    output logic [NUM_DIGITS*7-1:0] hex_out,
    output logic                    overflow
);

    localparam int BCD_DIGITS = bcd_digits(VALUE_W, NUM_DIGITS);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_W + 1);

    disp_state_t             r_state;
    logic [BCD_W-1:0]        r_bcd;
    logic [VALUE_W-1:0]      r_shreg;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ready;
    logic [NUM_DIGITS*7-1:0] r_hex;
    logic                    r_ovf;

    logic [BCD_W-1:0]        w_bcd_adj;
    logic [BCD_W-1:0]        w_bcd_next;
    logic [VALUE_W-1:0]      w_shreg_next;
    logic                    w_ovf;
    logic                    w_seen;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [6:0]              w_seg [NUM_DIGITS];

    // Double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {w_bcd_next, w_shreg_next} = {w_bcd_adj, r_shreg} << 1;

    // Overflow from nibbles beyond the display, and leading-zero blanking
    // scanning from the most significant displayed digit downward.
    always_comb begin
        w_ovf   = 1'b0;
        w_seen  = 1'b0;
        w_blank = '0;
        for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_ovf = 1'b1;
            end
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            w_blank[i] = (BLANK_LEADING != 0) && !w_seen && (i != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_decode u_dec (
            .i_digit (r_bcd[4*g +: 4]),
            .o_seg   (w_seg[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_bcd   <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_hex   <= {NUM_DIGITS{SEG_BLANK}};
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (value_valid && r_ready) begin
                        r_shreg <= value_in;
                        r_bcd   <= '0;
                        r_cnt   <= CNT_W'(VALUE_W);
                        r_ready <= 1'b0;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd   <= w_bcd_next;
                    r_shreg <= w_shreg_next;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_ovf) begin
                            r_hex[7*i +: 7] <= SEG_DASH;
                        end else if (w_blank[i]) begin
                            r_hex[7*i +: 7] <= SEG_BLANK;
                        end else begin
                            r_hex[7*i +: 7] <= w_seg[i];
                        end
                    end
                    r_ovf   <= w_ovf;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign value_ready = r_ready;
    assign overflow    = r_ovf;

`ifdef FLOOR_DISPLAY_BLINK_EN
    localparam int PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic               r_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_presc == PRESC_W'(BLINK_DIV - 1)) begin
            r_presc <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Blanking only masks the output; r_hex keeps the value underneath.
    assign hex_out = (moving && r_phase) ? {NUM_DIGITS{SEG_BLANK}} : r_hex;
`else
    localparam int c_blink_div_unused = BLINK_DIV;
    logic w_unused_moving;
    assign w_unused_moving = moving;
    assign hex_out = r_hex;
`endif

endmodule
`default_nettype wire
